// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_pkg
// Purpose  : Shared constants and helpers for the programmable serial
//            pattern detector (length limits, mode encodings, the
//            length-field width function).
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package seq_detect_pkg;

  // Upper bound on the pattern length any instance may be built for.
  localparam int SEQ_MAX_LEN_LIM = 32;

  // Match-mode encodings for cfg_overlap / the active ovl flag.
  localparam logic MODE_NOVL = 1'b0;
  localparam logic MODE_OVL  = 1'b1;

  // Width of a field able to hold every length value 0..max_len.
  function automatic int clen(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage : seq_detect_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at its all-ones value; synchronous
//            clear has priority over increment.
// Ports    : clk   in   clock, rising edge
//            rst_n in   asynchronous active-low reset
//            inc   in   count one event this cycle
//            clr   in   synchronous clear (wins over inc)
//            cnt   out  W-bit saturating count
// Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_prog
// Purpose  : Runtime-programmable serial bit-pattern detector. Compares a
//            sliding window of received bits against a loadable pattern of
//            selectable length, in overlapping or non-overlapping mode.
// Ports    : clk, rst_n           clock / async active-low reset
//            in_valid, x          qualified serial bit
//            cfg_load             strobe loading cfg_pattern/cfg_len/cfg_overlap
//            cfg_pattern          right-aligned pattern, bit len-1 received first
//            cfg_len              pattern length (legal 2..MAX_LEN)
//            cfg_overlap          1 = overlapping matches allowed
//            cnt_clr              synchronous clear of match_cnt
//            z                    Mealy match (same cycle as last pattern bit)
//            z_q                  z delayed one cycle
//            match_cnt            saturating match count
//            cfg_err              one-cycle pulse on an illegal load
// Revision : 1.0  initial release
// ============================================================================
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(8'b0010_1011),
  parameter int                 LEN_RST = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      x,
  input  logic                      cfg_load,
  input  logic [MAX_LEN-1:0]        cfg_pattern,
  input  logic [clen(MAX_LEN)-1:0]  cfg_len,
  input  logic                      cfg_overlap,
  input  logic                      cnt_clr,
  output logic                      z,
  output logic                      z_q,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      cfg_err
);

  localparam int LW = clen(MAX_LEN);

  if (MAX_LEN < 2 || MAX_LEN > SEQ_MAX_LEN_LIM) begin : g_bad_max_len
    $error("seq_detect_prog: MAX_LEN out of range");
  end

  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0]      hcnt_q, hcnt_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               z_q_d;
  logic               cfg_err_q, cfg_err_d;

  // Full comparison window: stored history plus the bit arriving now.
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] bit_ok;
  logic               hist_full;
  logic               cfg_ok;

  assign window = {hist_q, x};

  // Positions at or above the active length are don't-care, so the compare
  // collapses to the low len bits of the window.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    assign bit_ok[i] = (LW'(i) >= len_q) || (window[i] == pat_q[i]);
  end

  // len_q is never below 2, so len_q-1 cannot wrap.
  assign hist_full = (hcnt_q >= (len_q - LW'(1)));
  assign z         = in_valid && !cfg_load && hist_full && (&bit_ok);
  assign cfg_ok    = (cfg_len >= LW'(2)) && (cfg_len <= LW'(MAX_LEN));

  always_comb begin
    hist_d    = hist_q;
    hcnt_d    = hcnt_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    z_q_d     = z;
    cfg_err_d = 1'b0;

    if (cfg_load) begin
      // Any bit presented with a load is dropped; history restarts either way.
      hcnt_d = '0;
      if (cfg_ok) begin
        pat_d = cfg_pattern;
        len_d = cfg_len;
        ovl_d = cfg_overlap;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (in_valid) begin
      hist_d = window[MAX_LEN-2:0];
      if (z && (ovl_q == MODE_NOVL)) begin
        // Consumed bits may not contribute to the next match.
        hcnt_d = '0;
      end else if (hcnt_q != LW'(MAX_LEN - 1)) begin
        hcnt_d = hcnt_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      hcnt_q    <= '0;
      pat_q     <= PAT_RST;
      len_q     <= LW'(LEN_RST);
      ovl_q     <= MODE_OVL;
      z_q       <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      hcnt_q    <= hcnt_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      z_q       <= z_q_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (z),
    .clr   (cnt_clr),
    .cnt   (match_cnt)
  );

endmodule : seq_detect_prog
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_prog
// Purpose  : Self-checking bench for seq_detect_prog (MAX_LEN=8, CNT_W=8).
//            Directed scenarios plus a randomized run against a queue-based
//            reference model of the detector.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, x, cfg_load, cfg_overlap, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       z, z_q, cfg_err;
  logic [7:0] match_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the valid bits still eligible to form a match.
  bit       m_hist[$];
  int       m_len;
  bit [7:0] m_pat;
  bit       m_ovl;
  int       m_cnt;
  bit       m_zq;
  bit       m_err;

  always #5 clk = ~clk;

  seq_detect_prog #(
    .MAX_LEN (8),
    .CNT_W   (8),
    .PAT_RST (8'b0010_1011),
    .LEN_RST (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .x           (x),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .z           (z),
    .z_q         (z_q),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err)
  );

  task automatic model_reset();
    m_hist.delete();
    m_pat = 8'b0010_1011;
    m_len = 6;
    m_ovl = 1'b1;
    m_cnt = 0;
    m_zq  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0; x = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One data cycle. az = DUT z sampled mid-cycle, ez = model z.
  task automatic do_bit(input logic v, input logic b, input logic clr,
                        output logic az, output logic ez);
    @(negedge clk);
    in_valid = v; x = b; cfg_load = 1'b0; cnt_clr = clr;
    #1;
    az = z;
    ez = 1'b0;
    if (v) begin
      m_hist.push_back(b);
      if (m_hist.size() > 8) void'(m_hist.pop_front());
      if (m_hist.size() >= m_len) begin
        ez = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) ez = 1'b0;
      end
      if (ez && !m_ovl) m_hist.delete();
    end
    if (clr) m_cnt = 0;
    else if (ez && m_cnt < 255) m_cnt++;
    m_zq  = ez;
    m_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o,
                         input logic v, input logic b, output logic az);
    @(negedge clk);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    in_valid = v; x = b; cnt_clr = 1'b0;
    #1;
    az = z;
    if (l >= 2 && l <= 8) begin
      m_pat = p; m_len = int'(l); m_ovl = o;
    end
    m_err = !(l >= 2 && l <= 8);
    m_hist.delete();
    m_zq = 1'b0;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    logic az, ez;
    apply_reset();
    n_cmp++; if (z !== 1'b0) begin n_fail++; $display("FAIL rst_z: got %b want 0", z); end
    n_cmp++; if (z_q !== 1'b0) begin n_fail++; $display("FAIL rst_zq: got %b want 0", z_q); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", match_cnt); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", cfg_err); end
    release_reset();
    do_bit(1'b0, 1'b0, 1'b0, az, ez);
    n_cmp++; if (az !== 1'b0) begin n_fail++; $display("FAIL rst_idle_z: got %b want 0", az); end
  endtask

  task automatic test_overlap();
    logic [10:0] s = 11'b101_0110_1011;
    logic az, ez, want, prev;
    prev = 1'b0;
    for (int i = 0; i < 11; i++) begin
      do_bit(1'b1, s[10-i], 1'b0, az, ez);
      want = (i == 5) || (i == 10);
      n_cmp++; if (az !== want) begin n_fail++; $display("FAIL ovl_z bit%0d: got %b want %b", i + 1, az, want); end
      n_cmp++; if (z_q !== want) begin n_fail++; $display("FAIL ovl_zq bit%0d: got %b want %b", i + 1, z_q, want); end
      prev = want;
    end
    do_bit(1'b0, 1'b0, 1'b0, az, ez);
    n_cmp++; if (z_q !== 1'b0) begin n_fail++; $display("FAIL ovl_zq_drop: got %b want 0", z_q); end
    n_cmp++; if (match_cnt !== 8'd2) begin n_fail++; $display("FAIL ovl_cnt: got %0d want 2", match_cnt); end
  endtask

  task automatic test_nonoverlap();
    logic [10:0] s = 11'b101_0110_1011;
    logic az, ez;
    do_load(8'h2B, 4'd6, 1'b0, 1'b0, 1'b0, az);
    do_bit(1'b0, 1'b0, 1'b1, az, ez);
    for (int i = 0; i < 11; i++) begin
      do_bit(1'b1, s[10-i], 1'b0, az, ez);
      n_cmp++; if (az !== (i == 5)) begin n_fail++; $display("FAIL novl_z bit%0d: got %b want %b", i + 1, az, (i == 5)); end
    end
    n_cmp++; if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL novl_cnt: got %0d want 1", match_cnt); end
  endtask

  task automatic test_repeat();
    logic az, ez;
    do_load(8'h0F, 4'd4, 1'b1, 1'b0, 1'b0, az);
    do_bit(1'b0, 1'b0, 1'b1, az, ez);
    for (int i = 0; i < 7; i++) begin
      do_bit(1'b1, 1'b1, 1'b0, az, ez);
      n_cmp++; if (az !== (i >= 3)) begin n_fail++; $display("FAIL rep_ovl_z bit%0d: got %b want %b", i + 1, az, (i >= 3)); end
    end
    n_cmp++; if (match_cnt !== 8'd4) begin n_fail++; $display("FAIL rep_ovl_cnt: got %0d want 4", match_cnt); end
    do_load(8'h0F, 4'd4, 1'b0, 1'b0, 1'b0, az);
    do_bit(1'b0, 1'b0, 1'b1, az, ez);
    for (int i = 0; i < 8; i++) begin
      do_bit(1'b1, 1'b1, 1'b0, az, ez);
      n_cmp++; if (az !== (i == 3 || i == 7)) begin n_fail++; $display("FAIL rep_novl_z bit%0d: got %b want %b", i + 1, az, (i == 3 || i == 7)); end
    end
    n_cmp++; if (match_cnt !== 8'd2) begin n_fail++; $display("FAIL rep_novl_cnt: got %0d want 2", match_cnt); end
  endtask

  task automatic test_bubbles_reset();
    logic [5:0] p = 6'b101011;
    logic [8:0] s = 9'b011_101011;
    logic az, ez;
    do_load(8'h2B, 4'd6, 1'b1, 1'b0, 1'b0, az);
    do_bit(1'b0, 1'b0, 1'b1, az, ez);
    for (int i = 0; i < 6; i++) begin
      do_bit(1'b0, ~p[5-i], 1'b0, az, ez);
      n_cmp++; if (az !== 1'b0) begin n_fail++; $display("FAIL bub_gap_z %0d: got %b want 0", i, az); end
      do_bit(1'b1, p[5-i], 1'b0, az, ez);
      n_cmp++; if (az !== (i == 5)) begin n_fail++; $display("FAIL bub_z bit%0d: got %b want %b", i + 1, az, (i == 5)); end
    end
    n_cmp++; if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL bub_cnt: got %0d want 1", match_cnt); end
    for (int i = 0; i < 4; i++) do_bit(1'b1, p[5-i], 1'b0, az, ez);
    apply_reset();
    n_cmp++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d want 0", match_cnt); end
    release_reset();
    for (int i = 0; i < 9; i++) begin
      do_bit(1'b1, s[8-i], 1'b0, az, ez);
      n_cmp++; if (az !== (i == 8)) begin n_fail++; $display("FAIL midrst_z bit%0d: got %b want %b", i + 1, az, (i == 8)); end
    end
  endtask

  task automatic test_cfg_edges();
    logic [5:0] p = 6'b101011;
    logic [7:0] a = 8'hA5;
    logic az, ez;
    logic [3:0] bad [2];
    bad[0] = 4'd1; bad[1] = 4'd9;
    for (int j = 0; j < 2; j++) begin
      do_load(8'h0F, bad[j], 1'b0, 1'b0, 1'b0, az);
      n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse len%0d: got %b want 1", bad[j], cfg_err); end
      do_bit(1'b0, 1'b0, 1'b0, az, ez);
      n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_clear len%0d: got %b want 0", bad[j], cfg_err); end
    end
    for (int i = 0; i < 6; i++) begin
      do_bit(1'b1, p[5-i], 1'b0, az, ez);
      n_cmp++; if (az !== (i == 5)) begin n_fail++; $display("FAIL err_oldpat_z bit%0d: got %b want %b", i + 1, az, (i == 5)); end
    end
    for (int i = 0; i < 5; i++) do_bit(1'b1, p[5-i], 1'b0, az, ez);
    do_load(8'h2B, 4'd6, 1'b1, 1'b1, 1'b1, az);
    n_cmp++; if (az !== 1'b0) begin n_fail++; $display("FAIL load_last_z: got %b want 0", az); end
    do_bit(1'b1, 1'b1, 1'b0, az, ez);
    n_cmp++; if (az !== 1'b0) begin n_fail++; $display("FAIL load_discard_z: got %b want 0", az); end
    do_load(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, az);
    for (int i = 0; i < 8; i++) begin
      do_bit(1'b1, a[7-i], 1'b0, az, ez);
      n_cmp++; if (az !== (i == 7)) begin n_fail++; $display("FAIL len8_z bit%0d: got %b want %b", i + 1, az, (i == 7)); end
    end
    for (int i = 0; i < 8; i++) do_bit(1'b1, a[7-i], (i == 7), az, ez);
    n_cmp++; if (az !== 1'b1) begin n_fail++; $display("FAIL clr_match_z: got %b want 1", az); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_wins_cnt: got %0d want 0", match_cnt); end
  endtask

  task automatic test_saturate();
    logic az, ez;
    do_load(8'h0F, 4'd4, 1'b1, 1'b0, 1'b0, az);
    do_bit(1'b0, 1'b0, 1'b1, az, ez);
    for (int i = 0; i < 260; i++) do_bit(1'b1, 1'b1, 1'b0, az, ez);
    n_cmp++; if (az !== 1'b1) begin n_fail++; $display("FAIL sat_z: got %b want 1", az); end
    n_cmp++; if (match_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt: got %0d want 255", match_cnt); end
  endtask

  task automatic test_random();
    logic az, ez;
    int r;
    apply_reset();
    release_reset();
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_load(8'($urandom), 4'($urandom_range(1, 5)), 1'($urandom),
                1'($urandom), 1'($urandom), az);
        ez = 1'b0;
      end else begin
        do_bit(($urandom_range(0, 9) < 8), 1'($urandom), (r == 3), az, ez);
      end
      n_cmp++; if (az !== ez) begin n_fail++; $display("FAIL rnd_z cyc%0d: got %b want %b", n, az, ez); end
      n_cmp++; if (z_q !== m_zq) begin n_fail++; $display("FAIL rnd_zq cyc%0d: got %b want %b", n, z_q, m_zq); end
      n_cmp++; if (match_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt cyc%0d: got %0d want %0d", n, match_cnt, m_cnt); end
      n_cmp++; if (cfg_err !== m_err) begin n_fail++; $display("FAIL rnd_err cyc%0d: got %b want %b", n, cfg_err, m_err); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; x = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    model_reset();
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_repeat();
    test_bubbles_reset();
    test_cfg_edges();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_seq_detect_prog
`default_nettype wire

// File: doc/seq_detect_prog.md
# seq_detect_prog

Parametrised, runtime-programmable serial bit-pattern detector; the next generation of the fixed-pattern Mealy detector FSMs in this codebase. It accepts one qualified bit per cycle and compares a sliding history window against a loadable pattern of runtime-selectable length. Overlapping and non-overlapping match modes are supported. Outputs are a Mealy match pulse, a registered copy of it and a saturating match counter. It sits on serial-receive paths as a framing/sync-word detector.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits; legal range 2..32.
- `CNT_W`, 8: width of the match counter.
- `PAT_RST`, 8'b0010_1011: pattern value after reset, right-aligned (6-bit 101011).
- `LEN_RST`, 6: pattern length after reset.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `x` is sampled this cycle.
- `x`  in  1  serial data bit.
- `cfg_load`  in  1  one-cycle strobe that loads `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern`  in  MAX_LEN  pattern bits, right-aligned; bit `len-1` is the first bit received.
- `cfg_len`  in  $clog2(MAX_LEN+1)  pattern length.
- `cfg_overlap`  in  1  1 = overlapping mode, 0 = non-overlapping mode.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.
- `z`  out  1  Mealy match: combinational from the registered state plus the current `in_valid` and `x`.
- `z_q`  out  1  `z` registered; one cycle later.
- `match_cnt`  out  CNT_W  saturating count of matches.
- `cfg_err`  out  1  registered one-cycle pulse flagging an illegal load.

## Operation
- **State registers:**
  - `hist`: MAX_LEN-1 bits, newest bit at bit 0.
  - `hcnt`: valid-history count, saturating at MAX_LEN-1.
  - `pat`, `len`, `ovl`: the active configuration.
- **Match condition:** `z = in_valid && !cfg_load && hcnt >= len-1 && {hist[len-2:0], x} == pat[len-1:0]`.
- **On an `in_valid` cycle without a load:** shift `x` into `hist` and increment `hcnt`.
  - If `z=1` and `ovl=0`, `hcnt` is set to 0 instead, so the matched bits cannot start a new match.
  - If `ovl=1`, the history is kept and matches may share bits.
- **No `in_valid`:** the state holds and `z=0`.
- **Legal `cfg_load`** (`2 <= cfg_len <= MAX_LEN`):
  - Load `pat`, `len` and `ovl`, and clear `hcnt` to 0.
  - Any `in_valid` bit in the same cycle is discarded.
  - `match_cnt` is untouched.
- **Illegal `cfg_load`:** the configuration is unchanged, `cfg_err=1` for one cycle, and `hcnt` is still cleared.
- **`match_cnt`:** increments on every `z=1` and saturates at 2^CNT_W-1. If `cnt_clr` and `z` occur in the same cycle, `cnt_clr` wins and the result is 0.
- **Reset values:**
  - `hist=0`, `hcnt=0`, `pat=PAT_RST`, `len=LEN_RST`, `ovl=1`.
  - `z_q=0`, `match_cnt=0`, `cfg_err=0`.
  - `z=0`, because `hcnt=0 < len-1`.
- **Reset mid-stream:** the partial history is discarded immediately and asynchronously. The next match needs `len` fresh valid bits.

## Timing
- `z` is asserted in the same cycle as the final pattern bit; latency 0.
- `z_q`, `match_cnt` and `cfg_err` update on the next rising edge.
- A load takes effect from the cycle after the `cfg_load` strobe.
- Bubbles (`in_valid=0`) between bits are transparent; they neither break nor create matches.
- Overlap mode produces at most one match per valid bit.
- Non-overlap mode requires at least `len` valid bits between matches.
- `rst_n` assertion is asynchronous; deassertion must be synchronised to `clk` upstream.

## Structure
- **Package `seq_detect_pkg`:**
  - `SEQ_MAX_LEN_LIM = 32`.
  - Length-field width function `clen(MAX_LEN)`.
  - Mode constants `MODE_NOVL = 0` and `MODE_OVL = 1`.
- **Sub-module `sat_counter`** (`W` parameter; inputs `inc` and `clr`, `clr` priority). This module is reused for `match_cnt`.
- **Masked compare:** a generate loop masks the compare to `len` bits. There is no per-pattern state encoding; the shift-window form replaces the hand-enumerated FSM.

## Test plan
- **Reset defaults, overlap mode:** pattern 101011 (len 6, ovl 1), stream 1,0,1,0,1,1,0,1,0,1,1 (all valid) → `z=1` on bits 6 and 11 only; `match_cnt=2`; `z_q` pulses one cycle after each.
- **Non-overlap mode:** load 101011 with ovl=0, same stream → `z=1` on bit 6 only; `match_cnt=1`.
- **Repeating pattern:** load 1111 (len 4). Overlap, seven 1s → `z` on bits 4,5,6,7 (count 4). Non-overlap, eight 1s → `z` on bits 4 and 8 (count 2).
- **Bubbles and mid-stream reset:**
  - 101011 delivered with `in_valid=0` gaps between every bit → one match, on bit 6.
  - `rst_n` pulsed after bit 4 → no match until 6 new bits.
- **Config edges:**
  - `cfg_len=1` or `MAX_LEN+1` → `cfg_err` pulses once and the old pattern still matches.
  - `cfg_load` in the same cycle as the last pattern bit → `z=0` and the bit is discarded.
  - Length `MAX_LEN` pattern 8'hA5 → matches.
- **Counter:** with `CNT_W=2`, five matches → `match_cnt` holds at 3. `cnt_clr` together with a match → 0.
